// File: rtl/led_scan_driver.sv
// led_scan_driver: serial-loaded, double-buffered, PWM-dimmed LED digit scanner.
// Serial inputs are synchronised into osc_clk. Frame data swaps in only at a
// frame boundary, and brightness swaps in only at a PWM counter wrap.
// Optional feature macro: LEDSCAN_DEADTIME_EN (blank the first DEAD_CYC cycles of each scan step).
module led_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SEG_N      = 7,
    parameter int LED_N      = 7,
    parameter int PWM_W      = 12,
    parameter int SCAN_DIV   = 4,
    parameter int DEAD_CYC   = 1,
    localparam int REC_W     = 2*SEG_N + LED_N,
    localparam int SHIFT_W   = NUM_DIGITS*REC_W
) (
    input  logic               osc_clk,
    input  logic               rst_n,
    input  logic               ser_clk,
    input  logic               ser_data,
    input  logic               ser_latch,
    input  logic               ser_pwm,
    output logic [SHIFT_W-1:0] digit_out,
    output logic               heartbeat
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    if (SCAN_DIV < 1 || DEAD_CYC >= SCAN_DIV) begin : g_param_check
        $error("led_scan_driver: need SCAN_DIV >= 1 and DEAD_CYC < SCAN_DIV");
    end

    // synchroniser bit order: {pwm, latch, clk, data}; edge history only for the strobes
    logic [3:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]         hist_q, hist_d;
    logic [SHIFT_W-1:0] shift_q, shift_d, pending_q, pending_d, active_q, active_d;
    logic               pend_v_q, pend_v_d;
    logic [PWM_W-1:0]   bright_q, bright_d, bright_pend_q, bright_pend_d, cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [SEG_N-1:0]   seg_q, seg_d;
    logic [LED_N-1:0]   led_q, led_d;
    logic [SHIFT_W-1:0] digit_out_q, digit_out_d;
    logic               heartbeat_q, heartbeat_d;

    logic               clk_rise, latch_rise, pwm_rise;
    logic               step_end, frame_end, cnt_wrap, oe, blank;
    logic [REC_W-1:0]   rec;

    // next-state: sync/edge detect, serial buffers, PWM, scan strobes, output mask
    always_comb begin
        sync1_d       = {ser_pwm, ser_latch, ser_clk, ser_data};
        sync2_d       = sync1_q;
        hist_d        = sync2_q[3:1];
        {pwm_rise, latch_rise, clk_rise} = sync2_q[3:1] & ~hist_q;

        step_end      = (div_q == DIV_LAST);
        frame_end     = step_end & seg_q[SEG_N-1] & led_q[LED_N-1];
        cnt_wrap      = &cnt_q;
        oe            = (cnt_q < bright_q);
`ifdef LEDSCAN_DEADTIME_EN
        blank         = (div_q < DIV_W'(DEAD_CYC));
`else
        blank         = 1'b0;
`endif

        shift_d       = shift_q;
        pending_d     = pending_q;
        pend_v_d      = pend_v_q;
        active_d      = active_q;
        bright_pend_d = bright_pend_q;
        bright_d      = bright_q;

        // Boundary consumes the old pending first; a coincident latch then re-arms it.
        if (frame_end && pend_v_q) begin
            active_d = pending_q;
            pend_v_d = 1'b0;
        end
        if (latch_rise) begin
            pending_d = shift_q;
            pend_v_d  = 1'b1;
        end
        if (cnt_wrap) begin
            bright_d = bright_pend_q;
        end
        if (pwm_rise) begin
            bright_pend_d = shift_q[PWM_W-1:0];
        end
        if (clk_rise) begin
            shift_d = {shift_q[SHIFT_W-2:0], sync2_q[0]};
        end

        cnt_d = cnt_q + PWM_W'(1);
        div_d = step_end ? '0 : div_q + DIV_W'(1);
        led_d = led_q;
        seg_d = seg_q;
        if (step_end) begin
            led_d = (led_q << 1) | (led_q >> (LED_N-1));
            if (led_q[LED_N-1]) begin
                seg_d = (seg_q << 1) | (seg_q >> (SEG_N-1));
            end
        end

        rec         = '0;
        digit_out_d = '0;
        if (oe && !blank) begin
            for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
                rec = active_q[d*REC_W +: REC_W];
                digit_out_d[d*REC_W +: REC_W] = {rec[REC_W-1 -: SEG_N] & seg_q,
                                                 rec[SEG_N+LED_N-1 -: SEG_N] & seg_q,
                                                 rec[LED_N-1:0] & led_q};
            end
        end
        heartbeat_d = oe;
    end

    // state register with synchronous active-low reset
    always_ff @(posedge osc_clk) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            hist_q        <= '0;
            shift_q       <= '0;
            pending_q     <= '0;
            pend_v_q      <= 1'b0;
            active_q      <= '0;
            bright_pend_q <= '0;
            bright_q      <= '0;
            cnt_q         <= '0;
            div_q         <= '0;
            seg_q         <= SEG_N'(1);
            led_q         <= LED_N'(1);
            digit_out_q   <= '0;
            heartbeat_q   <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            hist_q        <= hist_d;
            shift_q       <= shift_d;
            pending_q     <= pending_d;
            pend_v_q      <= pend_v_d;
            active_q      <= active_d;
            bright_pend_q <= bright_pend_d;
            bright_q      <= bright_d;
            cnt_q         <= cnt_d;
            div_q         <= div_d;
            seg_q         <= seg_d;
            led_q         <= led_d;
            digit_out_q   <= digit_out_d;
            heartbeat_q   <= heartbeat_d;
        end
    end

    assign digit_out = digit_out_q;
    assign heartbeat = heartbeat_q;

endmodule

// File: tb/tb_led_scan_driver.sv
// Testbench for led_scan_driver (default parameters). Honours LEDSCAN_DEADTIME_EN.
module tb_led_scan_driver;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_N      = 7;
    localparam int LED_N      = 7;
    localparam int PWM_W      = 12;
    localparam int SCAN_DIV   = 4;
    localparam int DEAD_CYC   = 1;
    localparam int REC_W      = 2*SEG_N + LED_N;
    localparam int SHIFT_W    = NUM_DIGITS*REC_W;
    localparam int STEPS      = SEG_N*LED_N;
    localparam int FRAME      = STEPS*SCAN_DIV;
    localparam int PERIOD     = 1 << PWM_W;

    logic osc_clk = 1'b0;
    logic rst_n = 1'b0;
    logic ser_clk = 1'b0, ser_data = 1'b0, ser_latch = 1'b0, ser_pwm = 1'b0;
    logic [SHIFT_W-1:0] digit_out;
    logic heartbeat;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    led_scan_driver #(
        .NUM_DIGITS(NUM_DIGITS), .SEG_N(SEG_N), .LED_N(LED_N),
        .PWM_W(PWM_W), .SCAN_DIV(SCAN_DIV), .DEAD_CYC(DEAD_CYC)
    ) dut (
        .osc_clk(osc_clk), .rst_n(rst_n), .ser_clk(ser_clk), .ser_data(ser_data),
        .ser_latch(ser_latch), .ser_pwm(ser_pwm), .digit_out(digit_out), .heartbeat(heartbeat)
    );

    always #5 osc_clk = ~osc_clk;

    task automatic check_eq(input string tag, input logic [SHIFT_W-1:0] got, input logic [SHIFT_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: time is a cycle count n since reset; scan position and PWM
    // phase are plain arithmetic on n, serial strobes take effect 3 edges after the pin.
    logic [SHIFT_W-1:0] m_shift, m_pend, m_act, exp_do;
    logic [PWM_W-1:0]   m_bp, m_br;
    logic               m_pv, exp_hb;
    logic               started = 1'b0;
    logic [2:0]         h_clk, h_dat, h_lat, h_pwm;
    int unsigned        m_n, out_n;

    task automatic model_step();
        int unsigned s, l;
        logic oe, blank, rc, rl, rp, bnd, wrap;
        logic [REC_W-1:0] rec;
        if (!rst_n) begin
            m_shift = '0; m_pend = '0; m_act = '0; m_pv = 1'b0; m_bp = '0; m_br = '0;
            h_clk = '0; h_dat = '0; h_lat = '0; h_pwm = '0;
            m_n = 0; out_n = 0; exp_do = '0; exp_hb = 1'b0; started = 1'b1;
            return;
        end
        oe    = (m_n % PERIOD) < m_br;
        blank = 1'b0;
`ifdef LEDSCAN_DEADTIME_EN
        blank = (m_n % SCAN_DIV) < DEAD_CYC;
`endif
        s = (m_n / (SCAN_DIV*LED_N)) % SEG_N;
        l = (m_n / SCAN_DIV) % LED_N;
        exp_do = '0;
        if (oe && !blank) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                rec = m_act[d*REC_W +: REC_W];
                exp_do[d*REC_W + SEG_N + LED_N + s] = rec[SEG_N + LED_N + s];
                exp_do[d*REC_W + LED_N + s]         = rec[LED_N + s];
                exp_do[d*REC_W + l]                 = rec[l];
            end
        end
        exp_hb = oe;
        out_n  = m_n;

        rc   = h_clk[1] & ~h_clk[2];
        rl   = h_lat[1] & ~h_lat[2];
        rp   = h_pwm[1] & ~h_pwm[2];
        bnd  = (m_n % FRAME) == FRAME - 1;
        wrap = (m_n % PERIOD) == PERIOD - 1;
        if (bnd && m_pv) begin m_act = m_pend; m_pv = 1'b0; end
        if (rl) begin m_pend = m_shift; m_pv = 1'b1; end
        if (wrap) m_br = m_bp;
        if (rp) m_bp = m_shift[PWM_W-1:0];
        if (rc) m_shift = {m_shift[SHIFT_W-2:0], h_dat[1]};
        h_clk = {h_clk[1:0], ser_clk};
        h_dat = {h_dat[1:0], ser_data};
        h_lat = {h_lat[1:0], ser_latch};
        h_pwm = {h_pwm[1:0], ser_pwm};
        m_n++;
    endtask

    initial forever begin
        @(posedge osc_clk);
        model_step();
    end

    initial forever begin
        @(negedge osc_clk);
        if (started) begin
            check_eq("digit_out", digit_out, exp_do);
            check_eq("heartbeat", heartbeat, exp_hb);
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [SHIFT_W-1:0] rand_pat();
        return SHIFT_W'({$urandom, $urandom, $urandom});
    endfunction

    task automatic send_bit(input logic b);
        ser_data = b;
        repeat (3) @(negedge osc_clk);
        ser_clk = 1'b1;
        repeat (4) @(negedge osc_clk);
        ser_clk = 1'b0;
        repeat (2) @(negedge osc_clk);
    endtask

    task automatic shift_word(input logic [SHIFT_W-1:0] v, input int nb);
        for (int i = nb - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic pulse(input logic lat, input logic pwm);
        ser_latch = lat;
        ser_pwm   = pwm;
        repeat (4) @(negedge osc_clk);
        ser_latch = 1'b0;
        ser_pwm   = 1'b0;
        repeat (4) @(negedge osc_clk);
    endtask

    task automatic wait_align(input int val, input string tag);
        int k = 0;
        while ((out_n % FRAME) != val && k < 5000) begin @(negedge osc_clk); k++; end
        check_eq(tag, ((out_n % FRAME) == val), 1'b1);
    endtask

    task automatic wait_bright(input logic [PWM_W-1:0] target);
        int k = 0;
        while (m_br != target && k < 6000) begin @(negedge osc_clk); k++; end
        check_eq("bright_wait", m_br, target);
    endtask

    task automatic wait_pend();
        int k = 0;
        while (m_pv && k < 600) begin @(negedge osc_clk); k++; end
        check_eq("pend_wait", m_pv, 1'b0);
    endtask

    task automatic count_hb(output int c);
        c = 0;
        for (int i = 0; i < PERIOD; i++) begin @(negedge osc_clk); c += int'(heartbeat); end
    endtask

    // One aligned frame of observations: OR of all strobed outputs rebuilds the active frame.
    logic [SHIFT_W-1:0] cap_rec;
    int cap_badpop, cap_visit, cap_zfirst, cap_nfirst, cap_zother;

    task automatic capture();
        bit seen [STEPS];
        int s, l;
        bit first;
        for (int i = 0; i < STEPS; i++) seen[i] = 1'b0;
        cap_rec = '0; cap_badpop = 0; cap_visit = 0; cap_zfirst = 0; cap_nfirst = 0; cap_zother = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge osc_clk);
            cap_rec |= digit_out;
            if (exp_hb) begin
                first = (out_n % SCAN_DIV) == 0;
                if (first) cap_nfirst++;
                if (digit_out == '0) begin
                    if (first) cap_zfirst++; else cap_zother++;
                end else begin
                    s = 0; l = 0;
                    for (int d = 0; d < NUM_DIGITS; d++)
                        if ($countones(digit_out[d*REC_W +: REC_W]) != 3) cap_badpop++;
                    for (int j = 0; j < SEG_N; j++) if (digit_out[SEG_N + LED_N + j]) s = j;
                    for (int j = 0; j < LED_N; j++) if (digit_out[j]) l = j;
                    seen[s*LED_N + l] = 1'b1;
                end
            end
        end
        for (int i = 0; i < STEPS; i++) cap_visit += int'(seen[i]);
    endtask

    initial begin
        logic [SHIFT_W-1:0] pa, pb, pc, pp;
        logic v;
        int c, nz;

        // reset with random serial activity
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge osc_clk);
            {ser_clk, ser_data, ser_latch, ser_pwm} = 4'($urandom);
        end
        check_eq("rst_digit_out", digit_out, '0);
        check_eq("rst_heartbeat", heartbeat, 1'b0);
        @(negedge osc_clk);
        {ser_clk, ser_data, ser_latch, ser_pwm} = 4'b0;
        rst_n = 1'b1;

        nz = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge osc_clk);
            if (digit_out != '0 || heartbeat) nz++;
        end
        check_eq("idle_quiet", nz, 0);

        // full-on: all ones, latch and pwm on the same cycle
        shift_word('1, SHIFT_W);
        pulse(1'b1, 1'b1);
        wait_bright('1);
        wait_pend();
        wait_align(0, "align_full");
        capture();
        check_eq("full_frame", cap_rec, '1);
        check_eq("full_popcount", cap_badpop, 0);
        check_eq("full_steps", cap_visit, STEPS);
`ifdef LEDSCAN_DEADTIME_EN
        check_eq("dead_first_blank", cap_zfirst, cap_nfirst);
`else
        check_eq("dead_first_lit", cap_zfirst, 0);
`endif
        check_eq("dead_others_lit", cap_zother, 0);
        count_hb(c);
        check_eq("pwm_full", c, PERIOD - 1);

        // tear-free: latch mid-frame keeps the old frame until the boundary
        pa = rand_pat();
        shift_word(pa, SHIFT_W);
        wait_align(FRAME - 1, "align_a");
        fork
            pulse(1'b1, 1'b0);
            begin @(negedge osc_clk); capture(); end
        join
        check_eq("tear_hold_old", cap_rec, '1);
        wait_align(0, "align_a2");
        capture();
        check_eq("tear_new_a", cap_rec, pa);

        // B then C within one frame: last latch wins
        pb = rand_pat();
        shift_word(pb, SHIFT_W);
        v  = ~pb[0];
        pc = {pb[SHIFT_W-2:0], v};
        wait_align(FRAME - 1, "align_b");
        fork
            begin pulse(1'b1, 1'b0); send_bit(v); pulse(1'b1, 1'b0); end
            begin @(negedge osc_clk); capture(); end
        join
        check_eq("tear_hold_a", cap_rec, pa);
        wait_align(0, "align_c");
        capture();
        check_eq("tear_last_wins", cap_rec, pc);

        // reset mid-load discards the partial shift
        for (int i = 0; i < 40; i++) send_bit(1'($urandom));
        rst_n = 1'b0;
        repeat (2) @(negedge osc_clk);
        rst_n = 1'b1;
        pp = rand_pat() | SHIFT_W'({PWM_W{1'b1}});
        shift_word(pp, SHIFT_W);
        pulse(1'b1, 1'b1);
        wait_bright('1);
        wait_pend();
        wait_align(0, "align_reload");
        capture();
        check_eq("reload_frame", cap_rec, pp);

        // PWM duty
        shift_word(SHIFT_W'(2048), PWM_W);
        pulse(1'b0, 1'b1);
        wait_bright(12'd2048);
        count_hb(c);
        check_eq("pwm_half", c, 2048);
        shift_word('0, PWM_W);
        pulse(1'b0, 1'b1);
        wait_bright('0);
        count_hb(c);
        check_eq("pwm_off", c, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
